trivium_sched: RTL and testbench

- Sequencer and two-requester arbiter in front of one shared Trivium keystream engine (80-bit key, 80-bit IV, 288-bit state, one keystream bit per step).
- Grants the engine to one requester at a time, round-robin.
- For each session: loads key/IV, runs the 1152-step warm-up, then packs keystream bits into words returned over a valid/ready stream tagged with the requester ID.

---
 rtl/trivium_sched.sv | 125 ++++++++++++
 tb/tb_trivium_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_sched.sv
// Round-robin front end sharing one Trivium engine between two requesters: ack 1 cycle after grant, first word WARMUP+WORD_W+2 cycles after the request.
// A finished word parks in HOLD with ks_en low until out_ready, so the engine never advances past an unconsumed word.
module trivium_sched #(
   parameter int WARMUP = 1152,
   parameter int WORD_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [1:0]        req_valid,
   input  logic [79:0]       req_key0,
   input  logic [79:0]       req_key1,
   input  logic [79:0]       req_iv0,
   input  logic [79:0]       req_iv1,
   input  logic [LEN_W-1:0]  req_len0,
   input  logic [LEN_W-1:0]  req_len1,
   output logic [1:0]        req_ack,
   output logic              ks_load,
   output logic [79:0]       ks_key,
   output logic [79:0]       ks_iv,
   output logic              ks_en,
   input  logic              ks_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_id,
   output logic              out_last,
   output logic              busy
);

   localparam int STEP_W = $clog2(WARMUP + 1);
   localparam int CNT_W  = (STEP_W > $clog2(WORD_W)) ? STEP_W : $clog2(WORD_W);
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_WARM = 3'd2;
   localparam logic [2:0] S_GEN  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic [2:0]       state;
   logic             last_id;
   logic             sess_id;
   logic             win_id;
   logic [LEN_W-1:0] remaining;
   logic [CNT_W-1:0] cnt;

   // last_id resets to 1 so requester 0 wins the first contested grant
   always_comb begin
      win_id = 1'b0;
      case (req_valid)
         2'b01:   win_id = 1'b0;
         2'b10:   win_id = 1'b1;
         2'b11:   win_id = ~last_id;
         default: win_id = 1'b0;
      endcase
   end

   assign req_ack   = (state == S_LOAD) ? (sess_id ? 2'b10 : 2'b01) : 2'b00;
   assign ks_load   = (state == S_LOAD);
   assign ks_en     = (state == S_WARM) || (state == S_GEN);
   assign out_valid = (state == S_HOLD);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state     <= S_IDLE;
         last_id   <= 1'b1;
         sess_id   <= 1'b0;
         remaining <= '0;
         cnt       <= '0;
         ks_key    <= '0;
         ks_iv     <= '0;
         out_data  <= '0;
         out_id    <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req_valid) begin
                  sess_id   <= win_id;
                  last_id   <= win_id;
                  ks_key    <= win_id ? req_key1 : req_key0;
                  ks_iv     <= win_id ? req_iv1  : req_iv0;
                  remaining <= win_id ? req_len1 : req_len0;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               cnt   <= '0;
               state <= (remaining == '0) ? S_IDLE : S_WARM;
            end
            S_WARM: begin
               if (cnt == WARM_LAST) begin
                  cnt   <= '0;
                  state <= S_GEN;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_GEN: begin
               // out_data doubles as the packing register; it only shifts while out_valid is low
               out_data <= {out_data[WORD_W-2:0], ks_z};
               if (cnt == WORD_LAST) begin
                  cnt      <= '0;
                  out_id   <= sess_id;
                  out_last <= (remaining == LEN_W'(1));
                  state    <= S_HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  remaining <= remaining - LEN_W'(1);
                  state     <= (remaining == LEN_W'(1)) ? S_IDLE : S_GEN;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trivium_sched.sv
// Bench for trivium_sched: Trivium engine stub, keystream scoreboard, arbitration model and directed scenarios.
module tb_trivium_sched;

   localparam int WARMUP = 1152;
   localparam int WORD_W = 32;
   localparam int LEN_W  = 16;

   logic              CLK = 1'b0;
   logic              RSTn;
   logic [1:0]        req_valid;
   logic [79:0]       req_key0, req_key1, req_iv0, req_iv1;
   logic [LEN_W-1:0]  req_len0, req_len1;
   logic [1:0]        req_ack;
   logic              ks_load, ks_en, ks_z, out_valid, out_ready, out_id, out_last, busy;
   logic [79:0]       ks_key, ks_iv;
   logic [WORD_W-1:0] out_data;

   always #5 CLK = ~CLK;

   trivium_sched dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .req_valid (req_valid),
      .req_key0  (req_key0),
      .req_key1  (req_key1),
      .req_iv0   (req_iv0),
      .req_iv1   (req_iv1),
      .req_len0  (req_len0),
      .req_len1  (req_len1),
      .req_ack   (req_ack),
      .ks_load   (ks_load),
      .ks_key    (ks_key),
      .ks_iv     (ks_iv),
      .ks_en     (ks_en),
      .ks_z      (ks_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_last  (out_last),
      .busy      (busy)
   );

   int errors = 0;
   int checks = 0;

   // Trivium with s1 at bit 0: z = s66^s93^s162^s177^s243^s288
   function automatic bit tri_z(bit [287:0] s);
      return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
   endfunction

   function automatic bit [287:0] tri_step(bit [287:0] s);
      bit t1, t2, t3;
      t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
      t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
      t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
      return {s[286:177], t2, s[175:93], t1, s[91:0], t3};
   endfunction

   bit [287:0] eng = '0;
   assign ks_z = tri_z(eng);
   always @(posedge CLK) begin
      if (ks_load)    eng <= {3'b111, 112'b0, ks_iv, 13'b0, ks_key};
      else if (ks_en) eng <= tri_step(eng);
   end

   logic [WORD_W-1:0] exp_dat[$];
   int exp_id[$], exp_last[$];
   int grants[$], obs_id[$], obs_last[$], vrise[$];
   int ncyc = 0, en_cnt = 0, load_cnt = 0, hs_cnt = 0;
   int ack_cyc = 0, first_val_cyc = 0, en_at_valid = 0, w_m = 0;
   bit valid_seen = 0, prev_valid = 0, mdl_last = 1'b1, hold0 = 0, hold1 = 0;
   logic [1:0] prev_rv = 2'b00;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   task automatic timeout(string name, int n);
      checks++;
      errors++;
      $display("FAIL %s: no completion within %0d cycles (cycle %0d)", name, n, ncyc);
   endtask

   // Expected words of a session: keystream bits after WARMUP discards, grouped WORD_W at a time, first bit in MSB
   task automatic push_session(int id, logic [79:0] k, logic [79:0] v, int len);
      bit [287:0] s;
      bit ks[$];
      logic [WORD_W-1:0] word;
      s = {3'b111, 112'b0, v, 13'b0, k};
      for (int i = 0; i < WARMUP; i++) s = tri_step(s);
      for (int i = 0; i < len * WORD_W; i++) begin
         ks.push_back(tri_z(s));
         s = tri_step(s);
      end
      for (int w = 0; w < len; w++) begin
         word = '0;
         for (int b = 0; b < WORD_W; b++) word[WORD_W-1-b] = ks[w*WORD_W + b];
         exp_dat.push_back(word);
         exp_id.push_back(id);
         exp_last.push_back((w == len - 1) ? 1 : 0);
      end
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         ncyc++;
         if (RSTn === 1'b1) begin
            if (ks_en) en_cnt++;
            if (ks_load) load_cnt++;
            if (ks_en || ks_load || out_valid) chk("busy_active", busy, 1'b1);
            if (req_ack != 2'b00) begin
               if (prev_rv == 2'b11) w_m = mdl_last ? 0 : 1;
               else                  w_m = prev_rv[1] ? 1 : 0;
               chk("ack_grant", req_ack, (w_m == 1) ? 2'b10 : 2'b01);
               chk("ack_load", ks_load, 1'b1);
               chk("ks_key", ks_key, (w_m == 1) ? req_key1 : req_key0);
               chk("ks_iv", ks_iv, (w_m == 1) ? req_iv1 : req_iv0);
               push_session(w_m, (w_m == 1) ? req_key1 : req_key0, (w_m == 1) ? req_iv1 : req_iv0,
                            (w_m == 1) ? int'(req_len1) : int'(req_len0));
               mdl_last = (w_m == 1);
               grants.push_back(w_m);
               ack_cyc = ncyc;
               en_cnt = 0;
               valid_seen = 0;
            end else begin
               chk("load_without_ack", ks_load, 1'b0);
            end
            if (out_valid) begin
               chk("stall_ks_en", ks_en, 1'b0);
               if (!prev_valid) vrise.push_back(ncyc);
               if (!valid_seen) begin
                  valid_seen = 1;
                  first_val_cyc = ncyc;
                  en_at_valid = en_cnt;
               end
               if (exp_dat.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected no word (cycle %0d)", out_data, ncyc);
               end else begin
                  chk("out_data", out_data, exp_dat[0]);
                  chk("out_id", out_id, exp_id[0]);
                  chk("out_last", out_last, exp_last[0]);
                  if (out_ready) begin
                     obs_id.push_back(int'(out_id));
                     obs_last.push_back(int'(out_last));
                     void'(exp_dat.pop_front());
                     void'(exp_id.pop_front());
                     void'(exp_last.pop_front());
                     hs_cnt++;
                  end
               end
            end
         end
         prev_valid = out_valid;
         prev_rv = req_valid;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (req_ack[0] && !hold0) req_valid[0] = 1'b0;
      if (req_ack[1] && !hold1) req_valid[1] = 1'b0;
   endtask

   task automatic wait_idle(string name, int budget);
      int n = 0;
      while (!(req_valid == 2'b00 && !busy && exp_dat.size() == 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) timeout(name, n);
   endtask

   task automatic check_zero();
      chk("rst_req_ack", req_ack, 2'b00);
      chk("rst_ks_load", ks_load, 1'b0);
      chk("rst_ks_en", ks_en, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_id", out_id, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_ks_key", ks_key, '0);
      chk("rst_ks_iv", ks_iv, '0);
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      repeat (3) tick();
      check_zero();
      RSTn = 1'b1;
      exp_dat.delete();
      exp_id.delete();
      exp_last.delete();
      mdl_last = 1'b1;
      tick();
   endtask

   initial begin
      #6000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", ncyc);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      bit [287:0] ps;
      int t0, gi, oi, vi, n, hs0, lc0;
      int exp_g2[2] = '{0, 1};
      int exp_oid[4] = '{0, 0, 1, 1};
      int exp_olast[4] = '{0, 1, 0, 1};
      int exp_gf[6] = '{0, 1, 0, 1, 0, 1};

      RSTn = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
      req_key0 = '0; req_key1 = '0; req_iv0 = '0; req_iv1 = '0; req_len0 = '0; req_len1 = '0;

      // Un-warmed all-zero key/IV: only s286..s288 set, so z = 1,1,1,0
      ps = {3'b111, 285'b0};
      chk("pin_z1", tri_z(ps), 1'b1); ps = tri_step(ps);
      chk("pin_z2", tri_z(ps), 1'b1); ps = tri_step(ps);
      chk("pin_z3", tri_z(ps), 1'b1); ps = tri_step(ps);
      chk("pin_z4", tri_z(ps), 1'b0);

      // single request, zero key/IV
      do_reset();
      out_ready = 1'b1;
      req_len0 = 16'd1;
      t0 = ncyc + 1;
      req_valid[0] = 1'b1;
      wait_idle("single_done", 3000);
      chk("single_ack_cycle", ack_cyc - t0, 1);
      chk("single_first_valid", first_val_cyc - t0, 1186);
      chk("single_ks_en_count", en_at_valid, 1184);
      chk("single_busy_after", busy, 1'b0);

      // both requesters from reset
      do_reset();
      gi = grants.size(); oi = obs_id.size(); vi = vrise.size();
      req_key0 = 80'h0123456789ABCDEF0123; req_iv0 = 80'hFEDCBA98765432100000;
      req_key1 = 80'h80000000000000000001; req_iv1 = 80'h0000000000000000A5A5;
      req_len0 = 16'd2; req_len1 = 16'd2;
      req_valid = 2'b11;
      wait_idle("both_done", 6000);
      for (int i = 0; i < 2; i++)
         chk("both_grant_order", (grants.size() > gi + i) ? grants[gi + i] : -1, exp_g2[i]);
      for (int i = 0; i < 4; i++) begin
         chk("both_out_id_seq", (obs_id.size() > oi + i) ? obs_id[oi + i] : -1, exp_oid[i]);
         chk("both_out_last_seq", (obs_last.size() > oi + i) ? obs_last[oi + i] : -1, exp_olast[i]);
      end
      chk("both_word_gap", (vrise.size() > vi + 1) ? vrise[vi + 1] - vrise[vi] : -1, WORD_W + 1);

      // backpressure on word 2 of 3
      hs0 = hs_cnt; vi = vrise.size();
      req_key0 = 80'h0F62B5085BAE0154A7FA; req_iv0 = 80'h288FF65DC42B92F960C7; req_len0 = 16'd3;
      req_valid[0] = 1'b1;
      n = 0;
      while (hs_cnt < hs0 + 1 && n < 3000) begin tick(); n++; end
      if (n >= 3000) timeout("bp_first_word", n);
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      if (n >= 100) timeout("bp_second_word", n);
      repeat (50) tick();
      out_ready = 1'b1;
      wait_idle("bp_done", 500);
      chk("bp_words", hs_cnt - hs0, 3);
      chk("bp_valid_rises", vrise.size() - vi, 3);

      // reset during warm-up, then a fresh session
      req_key0 = 80'h3C3C_5A5A_0F0F_1234_ABCD; req_iv0 = 80'h1111_2222_3333_4444_5555; req_len0 = 16'd1;
      t0 = ncyc + 1;
      req_valid[0] = 1'b1;
      while (ncyc < t0 + 599) tick();
      RSTn = 1'b0;
      tick();
      check_zero();
      RSTn = 1'b1;
      exp_dat.delete(); exp_id.delete(); exp_last.delete();
      mdl_last = 1'b1;
      tick();
      req_key0 = 80'hDEAD_BEEF_0000_CAFE_F00D; req_iv0 = 80'h0000_0000_0000_0000_0001;
      hs0 = hs_cnt;
      req_valid[0] = 1'b1;
      wait_idle("post_reset_done", 3000);
      chk("post_reset_words", hs_cnt - hs0, 1);

      // zero-length request on requester 1
      lc0 = load_cnt; vi = vrise.size();
      req_len1 = '0;
      t0 = ncyc + 1;
      req_valid[1] = 1'b1;
      tick();
      chk("len0_ack", req_ack, 2'b10);
      chk("len0_busy_load", busy, 1'b1);
      tick();
      chk("len0_idle", busy, 1'b0);
      repeat (10) tick();
      chk("len0_ack_cycle", ack_cyc - t0, 1);
      chk("len0_no_ks_en", en_cnt, 0);
      chk("len0_one_load", load_cnt - lc0, 1);
      chk("len0_no_words", vrise.size() - vi, 0);

      // fairness: req0 held continuously, req1 joins mid-session
      gi = grants.size();
      req_len0 = 16'd1; req_len1 = 16'd1;
      hold0 = 1; req_valid[0] = 1'b1;
      n = 0;
      while (grants.size() <= gi && n < 100) begin tick(); n++; end
      if (n >= 100) timeout("fair_first_grant", n);
      repeat (100) tick();
      hold1 = 1; req_valid[1] = 1'b1;
      n = 0;
      while (grants.size() < gi + 5 && n < 8000) begin tick(); n++; end
      if (n >= 8000) timeout("fair_grants", n);
      hold0 = 0; hold1 = 0;
      req_valid[0] = 1'b0;
      wait_idle("fair_done", 3000);
      for (int i = 0; i < 6; i++)
         chk("fair_grant_order", (grants.size() > gi + i) ? grants[gi + i] : -1, exp_gf[i]);

      chk("scoreboard_drained", exp_dat.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
